// File: rtl/newton_raphson_pkg.sv
// rtl/newton_raphson_pkg.sv - shared FSM encoding and constants for the Newton-Raphson divider
package newton_raphson_pkg;

   typedef enum logic [2:0] {
      IDLE, NORM, SEED, ITER_A, ITER_B, MULQ, CORR, DONE
   } nr_state_t;

   // Linear seed coefficients num/17 scaled to frac fractional bits (use num = 48 or 32)
   function automatic logic [63:0] nr_seed_const(input int num, input int frac);
      return (64'(num) << frac) / 64'd17;
   endfunction

   function automatic int nr_latency(input int iters);
      return 4 + 2 * iters;
   endfunction

endpackage

// File: rtl/newton_raphson_divide_seq_lzc.sv
// rtl/newton_raphson_divide_seq_lzc.sv - combinational leading-zero count
module nr_lzc #(
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] a,
   output logic [CW-1:0]    count
);

   // Highest set bit wins because later iterations override earlier ones
   always_comb begin
      count = CW'(WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
         if (a[i]) count = CW'(WIDTH - 1 - i);
      end
   end

endmodule

// File: rtl/newton_raphson_divide_seq.sv
// rtl/newton_raphson_divide_seq.sv - sequential signed divider using a Newton-Raphson reciprocal
module newton_raphson_divide_seq
   import newton_raphson_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int ITERS = 3,
   parameter int FRAC  = 2 * WIDTH + 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] ne,
   input  logic [WIDTH-1:0] de,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] rem,
   output logic             dbz,
   output logic             ovf
);

   localparam int MW  = FRAC + 2;
   localparam int PW  = 2 * MW;
   localparam int QW  = WIDTH + 1;
   localparam int RW  = WIDTH + 3;
   localparam int LZW = $clog2(WIDTH + 1);
   localparam int SHW = $clog2(FRAC + WIDTH + 1);
   localparam int ITW = $clog2(ITERS + 1);
   localparam logic [MW-1:0] C48 = MW'(nr_seed_const(48, FRAC));
   localparam logic [MW-1:0] C32 = MW'(nr_seed_const(32, FRAC));
   localparam logic [MW-1:0] TWO = MW'(2) << FRAC;
   localparam logic [WIDTH-1:0] MIN_MAG = {1'b1, {(WIDTH-1){1'b0}}};

   nr_state_t state, nxt;

   logic             sn, sd;
   logic [WIDTH-1:0] an, ad;
   logic [MW-1:0]    d_fix, x, t;
   logic [SHW-1:0]   sh;
   logic [QW-1:0]    q;
   logic [ITW-1:0]   it;
   logic [WIDTH-1:0] out_q, rem_q;
   logic             dbz_q, ovf_q;

   logic [LZW-1:0]   lz;
   logic [MW-1:0]    mul_a, mul_b, prod_frac;
   logic [PW-1:0]    prod;
   logic signed [RW-1:0] r_raw, r_fix, r_out;
   logic [QW-1:0]    q_fix, q_out;

   nr_lzc #(.WIDTH(WIDTH)) u_lzc (.a(ad), .count(lz));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (in_valid) nxt = NORM;
         NORM:    nxt = SEED;
         SEED:    nxt = ITER_A;
         ITER_A:  nxt = ITER_B;
         ITER_B:  nxt = (it == ITW'(ITERS - 1)) ? MULQ : ITER_A;
         MULQ:    nxt = CORR;
         CORR:    nxt = DONE;
         DONE:    if (out_ready) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
      out       = out_valid ? out_q : '0;
      rem       = out_valid ? rem_q : '0;
      dbz       = out_valid & dbz_q;
      ovf       = out_valid & ovf_q;
   end

   // Single multiplier shared by every arithmetic step
   always_comb begin
      mul_a = '0;
      mul_b = '0;
      case (state)
         SEED:   begin mul_a = C32;       mul_b = d_fix;     end
         ITER_A: begin mul_a = d_fix;     mul_b = x;         end
         ITER_B: begin mul_a = x;         mul_b = TWO - t;   end
         MULQ:   begin mul_a = MW'(an);   mul_b = x;         end
         CORR:   begin mul_a = MW'(q);    mul_b = MW'(ad);   end
         default: ;
      endcase
   end

   assign prod      = PW'(mul_a) * PW'(mul_b);
   assign prod_frac = prod[FRAC +: MW];

   always_comb begin
      r_raw = $signed({3'b000, an}) - $signed(prod[RW-1:0]);
      q_fix = q;
      r_fix = r_raw;
      if (r_raw >= $signed({3'b000, ad})) begin
         q_fix = q + 1'b1;
         r_fix = r_raw - $signed({3'b000, ad});
      end else if (r_raw < 0) begin
         q_fix = q - 1'b1;
         r_fix = r_raw + $signed({3'b000, ad});
      end
      q_out = (sn ^ sd) ? -q_fix : q_fix;
      r_out = sn ? -r_fix : r_fix;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sn <= 1'b0;  sd <= 1'b0;  an <= '0;  ad <= '0;
         d_fix <= '0; x <= '0;  t <= '0;  sh <= '0;  q <= '0;  it <= '0;
         out_q <= '0; rem_q <= '0; dbz_q <= 1'b0; ovf_q <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               sn <= ne[WIDTH-1];
               sd <= de[WIDTH-1];
               an <= ne[WIDTH-1] ? -ne : ne;
               ad <= de[WIDTH-1] ? -de : de;
            end
            NORM: begin
               d_fix <= MW'(ad) << (FRAC - WIDTH + int'(lz));
               sh    <= SHW'(FRAC + WIDTH) - SHW'(lz);
               it    <= '0;
            end
            SEED:   x <= C48 - prod_frac;
            ITER_A: t <= prod_frac;
            ITER_B: begin
               x  <= prod_frac;
               it <= it + 1'b1;
            end
            MULQ:   q <= QW'(prod >> sh);
            CORR: begin
               dbz_q <= (ad == '0);
               ovf_q <= sn & sd & (an == MIN_MAG) & (ad == WIDTH'(1));
               if (ad == '0) begin
                  out_q <= '1;
                  rem_q <= sn ? -an : an;
               end else begin
                  out_q <= q_out[WIDTH-1:0];
                  rem_q <= r_out[WIDTH-1:0];
               end
            end
            default: ;
         endcase
      end
   end

endmodule
